// File: rtl/mod12_pass_sequencer.sv
// Pass sequencer for the shared mod-12 up/down counter: loads a start value,
// verifies the load, runs to the end value, and repeats for the programmed passes.
//
// state  | meaning
// IDLE   | ready for a command, counter free-runs upward
// LOAD   | cnt_load asserted with din=start, one cycle
// VERIFY | check that the counter took the start value
// RUN    | counter steps in dir until it reaches end
// DONE   | done pulse, all passes complete
// ERR    | err pulse with err_code valid
module mod12_pass_sequencer #(
  parameter int CW         = 4,
  parameter int MAXV       = 12,
  parameter int LOAD_TRIES = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_start,
  input  logic [CW-1:0] cmd_end,
  input  logic          cmd_dir,
  input  logic [3:0]    cmd_reps,
  input  logic          abort,
  output logic          cnt_mode,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_din,
  input  logic [CW-1:0] cnt_count,
  output logic          busy,
  output logic [3:0]    pass_idx,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          aborted
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, DONE, ERR} state_t;

  localparam int TW = $clog2(LOAD_TRIES + 1);
  localparam logic [CW-1:0] MAX_START = CW'(MAXV - 1);
  localparam logic [CW-1:0] MAX_END   = CW'(MAXV);
  // run_cnt value on the last RUN cycle of a full lap (MAXV+1 steps)
  localparam logic [3:0]    LAST_RUN  = 4'(MAXV);

  state_t        state;
  logic [CW-1:0] start_q;
  logic [CW-1:0] end_q;
  logic          dir_q;
  logic [3:0]    reps_q;
  logic [TW-1:0] tries;
  logic [3:0]    run_cnt;
  logic          cmd_legal;

  assign cmd_legal = (cmd_start != '0) && (cmd_start <= MAX_START) && (cmd_end <= MAX_END);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      start_q  <= '0;
      end_q    <= '0;
      dir_q    <= 1'b0;
      reps_q   <= '0;
      tries    <= '0;
      run_cnt  <= '0;
      pass_idx <= '0;
      err_code <= 2'd0;
      aborted  <= 1'b0;
    end else begin
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            start_q  <= cmd_start;
            end_q    <= cmd_end;
            dir_q    <= cmd_dir;
            reps_q   <= cmd_reps;
            pass_idx <= '0;
            tries    <= '0;
            if (cmd_legal) begin
              err_code <= 2'd0;
              state    <= LOAD;
            end else begin
              err_code <= 2'd1;
              state    <= ERR;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else begin
            tries <= tries + TW'(1);
            state <= VERIFY;
          end
        end
        VERIFY: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (cnt_count == start_q) begin
            run_cnt <= '0;
            state   <= RUN;
          end else if (tries < TW'(LOAD_TRIES)) begin
            state <= LOAD;
          end else begin
            err_code <= 2'd2;
            state    <= ERR;
          end
        end
        RUN: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (cnt_count == end_q) begin
            if (pass_idx == reps_q) begin
              state <= DONE;
            end else begin
              pass_idx <= pass_idx + 4'd1;
              tries    <= '0;
              state    <= LOAD;
            end
          end else if (run_cnt == LAST_RUN) begin
            err_code <= 2'd3;
            state    <= ERR;
          end else begin
            run_cnt <= run_cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outside an active pass the counter is left free-running upward
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cnt_load  = (state == LOAD);
  assign cnt_mode  = (state inside {LOAD, VERIFY, RUN}) ? dir_q : 1'b1;
  assign cnt_din   = start_q;
  assign done      = (state == DONE);
  assign err       = (state == ERR);

endmodule

// File: tb/tb_mod12_pass_sequencer.sv
// Directed bench for mod12_pass_sequencer with a behavioural mod-12 counter
// that can be switched to ignore loads or to stop counting.
module tb_mod12_pass_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic [3:0] cmd_end;
  logic       cmd_dir;
  logic [3:0] cmd_reps;
  logic       abort;
  logic       cnt_mode;
  logic       cnt_load;
  logic [3:0] cnt_din;
  logic [3:0] cnt_count;
  logic       busy;
  logic [3:0] pass_idx;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       aborted;

  int compared = 0;
  int mismatched = 0;
  int model_kind = 0;   // 0 normal, 1 ignores load, 2 loads but never steps
  int n_load = 0, n_done = 0, n_err = 0, n_abort = 0;
  logic [3:0] model_cnt;

  mod12_pass_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_dir(cmd_dir), .cmd_reps(cmd_reps),
    .abort(abort), .cnt_mode(cnt_mode), .cnt_load(cnt_load), .cnt_din(cnt_din),
    .cnt_count(cnt_count), .busy(busy), .pass_idx(pass_idx), .done(done), .err(err),
    .err_code(err_code), .aborted(aborted)
  );

  always #5 clock = ~clock;

  // Counter: wrap beats load, only din 1..11 loads
  always @(posedge clock) begin
    if (reset) model_cnt <= 4'd0;
    else if (model_kind == 2) begin
      if (cnt_load && cnt_din >= 4'd1 && cnt_din <= 4'd11) model_cnt <= cnt_din;
    end else if (cnt_mode && model_cnt == 4'd12) model_cnt <= 4'd0;
    else if (!cnt_mode && model_cnt == 4'd0) model_cnt <= 4'd12;
    else if (model_kind == 0 && cnt_load && cnt_din >= 4'd1 && cnt_din <= 4'd11) model_cnt <= cnt_din;
    else if (cnt_mode) model_cnt <= model_cnt + 4'd1;
    else model_cnt <= model_cnt - 4'd1;
  end
  assign cnt_count = model_cnt;

  always @(negedge clock) begin
    if (cnt_load === 1'b1) n_load <= n_load + 1;
    if (done === 1'b1) n_done <= n_done + 1;
    if (err === 1'b1) n_err <= n_err + 1;
    if (aborted === 1'b1) n_abort <= n_abort + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic d,
                       input logic [3:0] r, input logic ab);
    cmd_start = s; cmd_end = e; cmd_dir = d; cmd_reps = r;
    cmd_valid = 1'b1; abort = ab;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_count(input logic [3:0] v);
    for (int i = 0; i < 40 && cnt_count !== v; i++) tick();
    compared++;
    if (cnt_count !== v) begin
      mismatched++;
      $display("FAIL wait_count: counter=%0d never reached %0d", cnt_count, v);
    end
  endtask

  task automatic wait_end(input int max, output int cyc);
    cyc = 0;
    while (!(done === 1'b1 || err === 1'b1) && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_start = '0; cmd_end = '0; cmd_dir = 1'b0; cmd_reps = '0;
    repeat (3) tick();
    compared++;
    if ({cmd_ready, busy, cnt_load, cnt_mode, cnt_din, pass_idx, done, err, err_code, aborted}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_values: rdy=%b busy=%b ld=%b mode=%b din=%0d pass=%0d", cmd_ready, busy, cnt_load, cnt_mode, cnt_din, pass_idx);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_up_pass();
    wait_count(4'd0);
    issue(4'd3, 4'd7, 1'b1, 4'd0, 1'b0);
    compared++;
    if ({cnt_load, cnt_din, cnt_mode, busy, cmd_ready} !== {1'b1, 4'd3, 1'b1, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL up_load: ld=%b din=%0d mode=%b busy=%b rdy=%b, wanted 1 3 1 1 0", cnt_load, cnt_din, cnt_mode, busy, cmd_ready);
    end
    tick();
    compared++;
    if ({cnt_load, cnt_count} !== {1'b0, 4'd3}) begin
      mismatched++;
      $display("FAIL up_verify: ld=%b count=%0d, wanted 0 3", cnt_load, cnt_count);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      compared++;
      if ({cnt_count, done} !== {4'(3 + k), 1'b0}) begin
        mismatched++;
        $display("FAIL up_run: count=%0d done=%b, wanted %0d 0", cnt_count, done, 3 + k);
      end
    end
    tick();
    compared++;
    if ({done, err, pass_idx, busy} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL up_done: done=%b err=%b pass=%0d busy=%b, wanted 1 0 0 1", done, err, pass_idx, busy);
    end
    tick();
    compared++;
    if ({done, cmd_ready, busy, cnt_mode} !== {1'b0, 1'b1, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL up_idle: done=%b rdy=%b busy=%b mode=%b, wanted 0 1 0 1", done, cmd_ready, busy, cnt_mode);
    end
  endtask

  task automatic test_down_wrap();
    int seq[6];
    int b_load, b_done;
    seq = '{0, 2, 1, 0, 12, 11};
    wait_count(4'd3);
    b_load = n_load; b_done = n_done;
    issue(4'd2, 4'd11, 1'b0, 4'd2, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) begin
        compared++;
        if ({cnt_load, pass_idx, cnt_mode, done} !== {(i == 0), 4'(p), 1'b0, 1'b0}) begin
          mismatched++;
          $display("FAIL down_ctrl p%0d c%0d: ld=%b pass=%0d mode=%b done=%b", p, i, cnt_load, pass_idx, cnt_mode, done);
        end
        if (i > 0) begin
          compared++;
          if (cnt_count !== 4'(seq[i])) begin
            mismatched++;
            $display("FAIL down_count p%0d c%0d: count=%0d wanted %0d", p, i, cnt_count, seq[i]);
          end
        end
        tick();
      end
    end
    compared++;
    if ({done, err, pass_idx} !== {1'b1, 1'b0, 4'd2}) begin
      mismatched++;
      $display("FAIL down_done: done=%b err=%b pass=%0d, wanted 1 0 2", done, err, pass_idx);
    end
    tick();
    compared++;
    if ({done, pass_idx, n_load - b_load, n_done - b_done} !== {1'b0, 4'd2, 32'd3, 32'd1}) begin
      mismatched++;
      $display("FAIL down_totals: done=%b pass=%0d loads=%0d dones=%0d, wanted 0 2 3 1", done, pass_idx, n_load - b_load, n_done - b_done);
    end
  endtask

  task automatic test_load_retry();
    int cyc, b_load, b_err;
    wait_count(4'd12);
    b_load = n_load; b_err = n_err;
    issue(4'd5, 4'd3, 1'b0, 4'd0, 1'b0);
    compared++;
    if ({cnt_load, cnt_count} !== {1'b1, 4'd0}) begin
      mismatched++;
      $display("FAIL retry_load1: ld=%b count=%0d, wanted 1 0", cnt_load, cnt_count);
    end
    tick();
    compared++;
    if ({cnt_load, cnt_count} !== {1'b0, 4'd12}) begin
      mismatched++;
      $display("FAIL retry_verify1: ld=%b count=%0d, wanted 0 12", cnt_load, cnt_count);
    end
    tick();
    compared++;
    if (cnt_load !== 1'b1) begin
      mismatched++;
      $display("FAIL retry_load2: ld=%b wanted 1", cnt_load);
    end
    tick();
    compared++;
    if ({cnt_load, cnt_count} !== {1'b0, 4'd5}) begin
      mismatched++;
      $display("FAIL retry_verify2: ld=%b count=%0d, wanted 0 5", cnt_load, cnt_count);
    end
    wait_end(10, cyc);
    compared++;
    if ({done, err, cyc, n_load - b_load, n_err - b_err} !== {1'b1, 1'b0, 32'd3, 32'd2, 32'd0}) begin
      mismatched++;
      $display("FAIL retry_done: done=%b err=%b cyc=%0d loads=%0d errs=%0d, wanted 1 0 3 2 0", done, err, cyc, n_load - b_load, n_err - b_err);
    end
    tick();
    model_kind = 1;
    wait_count(4'd6);
    b_load = n_load;
    issue(4'd5, 4'd3, 1'b1, 4'd0, 1'b0);
    wait_end(12, cyc);
    compared++;
    if ({err, err_code, done, cyc} !== {1'b1, 2'd2, 1'b0, 32'd6}) begin
      mismatched++;
      $display("FAIL load_fail: err=%b code=%0d done=%b cyc=%0d, wanted 1 2 0 6", err, err_code, done, cyc);
    end
    tick();
    compared++;
    if ({err, err_code, cmd_ready, n_load - b_load} !== {1'b0, 2'd2, 1'b1, 32'd3}) begin
      mismatched++;
      $display("FAIL load_fail_hold: err=%b code=%0d rdy=%b loads=%0d, wanted 0 2 1 3", err, err_code, cmd_ready, n_load - b_load);
    end
    model_kind = 0;
  endtask

  task automatic test_bad_cmd();
    logic [3:0] bad_s[3];
    logic [3:0] bad_e[3];
    int b_load;
    bad_s = '{4'd0, 4'd12, 4'd3};
    bad_e = '{4'd5, 4'd5, 4'd13};
    b_load = n_load;
    for (int i = 0; i < 3; i++) begin
      issue(bad_s[i], bad_e[i], 1'b1, 4'd0, 1'b0);
      compared++;
      if ({err, err_code, cnt_load, busy, done} !== {1'b1, 2'd1, 1'b0, 1'b1, 1'b0}) begin
        mismatched++;
        $display("FAIL bad_cmd%0d: err=%b code=%0d ld=%b busy=%b done=%b, wanted 1 1 0 1 0", i, err, err_code, cnt_load, busy, done);
      end
      tick();
      compared++;
      if ({err, err_code, cmd_ready} !== {1'b0, 2'd1, 1'b1}) begin
        mismatched++;
        $display("FAIL bad_cmd%0d_idle: err=%b code=%0d rdy=%b, wanted 0 1 1", i, err, err_code, cmd_ready);
      end
    end
    compared++;
    if (n_load - b_load !== 0) begin
      mismatched++;
      $display("FAIL bad_cmd_loads: loads=%0d wanted 0", n_load - b_load);
    end
  endtask

  task automatic test_full_lap();
    int cyc;
    wait_count(4'd0);
    issue(4'd6, 4'd6, 1'b1, 4'd0, 1'b0);
    compared++;
    if (err_code !== 2'd0) begin
      mismatched++;
      $display("FAIL accept_clears_code: code=%0d wanted 0", err_code);
    end
    wait_end(20, cyc);
    compared++;
    if ({done, err, cyc, cnt_count} !== {1'b1, 1'b0, 32'd15, 4'd7}) begin
      mismatched++;
      $display("FAIL full_lap: done=%b err=%b cyc=%0d count=%0d, wanted 1 0 15 7", done, err, cyc, cnt_count);
    end
    tick();
    model_kind = 2;
    issue(4'd5, 4'd6, 1'b1, 4'd0, 1'b0);
    wait_end(20, cyc);
    compared++;
    if ({err, err_code, done, cyc} !== {1'b1, 2'd3, 1'b0, 32'd15}) begin
      mismatched++;
      $display("FAIL timeout: err=%b code=%0d done=%b cyc=%0d, wanted 1 3 0 15", err, err_code, done, cyc);
    end
    tick();
    model_kind = 0;
  endtask

  task automatic test_abort();
    int cyc, b_done, b_abort;
    wait_count(4'd0);
    b_done = n_done;
    issue(4'd3, 4'd10, 1'b1, 4'd0, 1'b0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++;
    if ({aborted, cmd_ready, busy, cnt_mode, done, err, pass_idx} !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      mismatched++;
      $display("FAIL abort_run: ab=%b rdy=%b busy=%b mode=%b done=%b err=%b", aborted, cmd_ready, busy, cnt_mode, done, err);
    end
    tick();
    compared++;
    if ({aborted, n_done - b_done} !== {1'b0, 32'd0}) begin
      mismatched++;
      $display("FAIL abort_pulse: ab=%b dones=%0d, wanted 0 0", aborted, n_done - b_done);
    end
    wait_count(4'd0);
    b_abort = n_abort;
    issue(4'd3, 4'd5, 1'b1, 4'd0, 1'b1);
    compared++;
    if ({cnt_load, busy} !== {1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL abort_accept_load: ld=%b busy=%b, wanted 1 1", cnt_load, busy);
    end
    wait_end(10, cyc);
    compared++;
    if ({done, cyc, n_abort - b_abort} !== {1'b1, 32'd4, 32'd0}) begin
      mismatched++;
      $display("FAIL abort_accept_done: done=%b cyc=%0d aborts=%0d, wanted 1 4 0", done, cyc, n_abort - b_abort);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int b_done, b_err, b_abort;
    wait_count(4'd0);
    issue(4'd3, 4'd5, 1'b1, 4'd1, 1'b0);
    repeat (6) tick();
    compared++;
    if ({pass_idx, cnt_count, busy} !== {4'd1, 4'd4, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_mid_pre: pass=%0d count=%0d busy=%b, wanted 1 4 1", pass_idx, cnt_count, busy);
    end
    b_done = n_done; b_err = n_err; b_abort = n_abort;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if ({cmd_ready, busy, cnt_load, cnt_mode, cnt_din, pass_idx, done, err, err_code, aborted}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid: rdy=%b busy=%b ld=%b mode=%b din=%0d pass=%0d done=%b err=%b", cmd_ready, busy, cnt_load, cnt_mode, cnt_din, pass_idx, done, err);
    end
    repeat (2) tick();
    compared++;
    if ({n_done - b_done, n_err - b_err, n_abort - b_abort} !== {32'd0, 32'd0, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_mid_pulses: done=%0d err=%0d abort=%0d, wanted none", n_done - b_done, n_err - b_err, n_abort - b_abort);
    end
  endtask

  initial begin
    test_reset();
    test_up_pass();
    test_down_wrap();
    test_load_retry();
    test_bad_cmd();
    test_full_lap();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
